// File: rtl/dwt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dwt_pkg
// Description : Shared constants for the DWT high-pass scheduler: FSM state
//               encoding, subtract-unit latency and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dwt_pkg;

    // Registered latency of the external shared subtract unit, in cycles
    localparam int c_SUB_LAT = 1;

    // Scheduler FSM encoding
    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_EVEN  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_ODD   = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_DRAIN = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd4;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_fifo.sv
`default_nettype none
// ============================================================================
// Module      : coef_fifo
// Description : Synchronous FIFO holding {eol, coefficient} words with an
//               occupancy count. Head word is presented combinationally and
//               stays put until it is read.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_wr;
    logic               w_rd;

    // Writes into a full FIFO and reads from an empty one are dropped
    assign w_wr      = i_wr_en && (r_count != CNT_W'(DEPTH));
    assign w_rd      = i_rd_en && (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);

    // Storage, wrapping pointers and occupancy (simultaneous rd+wr keeps count)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dwt_hp_sched.sv
`default_nettype none
// ============================================================================
// Module      : dwt_hp_sched
// Description : Schedules pixel pairs of a frame onto a shared, registered
//               subtract unit and collects the high-pass coefficients with
//               row end markers into an output FIFO. Pair issue is throttled
//               so that queued plus in-flight results never exceed the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dwt_hp_sched
    import dwt_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int FIFO_D = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic [7:0] sub_p1,
    output logic [7:0] sub_p2,
    input  logic [7:0] sub_pout,
    output logic       coef_valid,
    output logic [7:0] coef_data,
    output logic       coef_eol,
    input  logic       coef_ready,
    output logic       busy,
    output logic       done
);

    localparam int c_PAIRS_ROW = IMG_W / 2;
    localparam int c_COL_W     = f_cnt_w(c_PAIRS_ROW);
    localparam int c_ROW_W     = f_cnt_w(IMG_H);
    localparam int c_CNT_W     = $clog2(FIFO_D + 1);
    localparam int c_PEND_W    = c_CNT_W + 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_PAIRS_ROW - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    logic [c_ST_W-1:0]   r_state;
    logic [7:0]          r_even;
    logic [7:0]          r_sub_p1;
    logic [7:0]          r_sub_p2;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [1:0]          r_inflight;
    logic [c_SUB_LAT:0]  r_vld_pipe;
    logic [c_SUB_LAT:0]  r_eol_pipe;

    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_empty;
    logic [8:0]          w_fifo_rd_data;
    logic [c_PEND_W-1:0] w_pending;
    logic                w_odd_ready;
    logic                w_issue;
    logic                w_col_last;
    logic                w_last_pair;
    logic                w_wr;
    logic                w_rd;

    // Everything already committed to the FIFO, whether stored or still in the pipe
    assign w_pending   = c_PEND_W'(w_fifo_count) + c_PEND_W'(r_inflight);
    assign w_odd_ready = (r_state == c_ST_ODD) && (w_pending < c_PEND_W'(FIFO_D));
    assign w_issue     = w_odd_ready && pix_valid;
    assign w_col_last  = (r_col == c_COL_LAST);
    assign w_last_pair = w_col_last && (r_row == c_ROW_LAST);

    // Result of a pair lands in the FIFO once its valid reaches the pipe end
    assign w_wr = r_vld_pipe[c_SUB_LAT];
    assign w_rd = coef_valid && coef_ready;

    assign pix_ready  = (r_state == c_ST_EVEN) || w_odd_ready;
    assign sub_p1     = r_sub_p1;
    assign sub_p2     = r_sub_p2;
    assign coef_valid = !w_fifo_empty;
    assign coef_data  = w_fifo_rd_data[7:0];
    assign coef_eol   = w_fifo_rd_data[8] && coef_valid;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);

    // Scheduler FSM: pairs pixels, issues operands and tracks frame position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_even   <= 8'h00;
            r_sub_p1 <= 8'h00;
            r_sub_p2 <= 8'h00;
            r_col    <= '0;
            r_row    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_EVEN;
                    end
                end
                c_ST_EVEN: begin
                    if (pix_valid) begin
                        r_even  <= pix_data;
                        r_state <= c_ST_ODD;
                    end
                end
                c_ST_ODD: begin
                    if (w_issue) begin
                        r_sub_p1 <= r_even;
                        r_sub_p2 <= pix_data;
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        r_state <= w_last_pair ? c_ST_DRAIN : c_ST_EVEN;
                    end
                end
                c_ST_DRAIN: begin
                    if ((r_inflight == 2'd0) && w_fifo_empty) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Valid/eol tags ride alongside the operands through the subtract latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_eol_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[c_SUB_LAT-1:0], w_issue};
            r_eol_pipe <= {r_eol_pipe[c_SUB_LAT-1:0], w_col_last};
        end
    end

    // Pairs issued but not yet written into the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 2'd0;
        end else begin
            case ({w_issue, w_wr})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    coef_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (9),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data ({r_eol_pipe[c_SUB_LAT], sub_pout}),
        .i_rd_en   (w_rd),
        .o_rd_data (w_fifo_rd_data),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

endmodule
`default_nettype wire
